// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: state geometry, FSM encoding and byte-position helpers.
package aes_pkg;

  localparam int unsigned AES_NB_BYTES = 16;
  localparam int unsigned AES_STATE_W  = 128;
  localparam int unsigned AES_IDX_W    = 4;
  localparam int unsigned AES_LSB_W    = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } aes_fsm_e;

  // Byte i = r + 4c lives at [127-8i -: 8]; its lsb is 8*(15-i), and 15-i is ~i in 4 bits.
  function automatic logic [AES_LSB_W-1:0] byte_lsb(input logic [1:0] r, input logic [1:0] c);
    return {~{c, r}, 3'b000};
  endfunction

  function automatic logic [AES_IDX_W-1:0] byte_idx(input logic [1:0] r, input logic [1:0] c);
    return {c, r};
  endfunction

  // ShiftRows moves (r,c) to (r, c-r mod 4).
  function automatic logic [AES_IDX_W-1:0] shift_dst(input logic [1:0] r, input logic [1:0] c);
    return byte_idx(r, 2'(c - r));
  endfunction

endpackage

// File: rtl/sbox.sv
// AES forward S-box: GF(2^8) inverse (x^254) followed by the FIPS-197 affine transform.
module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] acc;
    p   = x;
    acc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) acc = acc ^ p;
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // Square-and-multiply over exponents 2,4,...,128 (sum 254); zero maps to zero naturally.
  always_comb begin
    sq  = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_sub_shift_serial.sv
// Byte-serial SubBytes + optional ShiftRows: one shared S-box, 16 cycles per state.
module aes_sub_shift_serial
  import aes_pkg::*;
#(
  parameter bit SHIFT_ROWS = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] state_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] state_out,
  output logic                   busy
);

  aes_fsm_e               state;
  aes_fsm_e               state_nxt;
  logic                   accept;
  logic [AES_IDX_W-1:0]   cnt;
  logic [AES_STATE_W-1:0] in_reg;
  logic [AES_STATE_W-1:0] out_reg;
  logic [AES_IDX_W-1:0]   dst;
  logic [AES_LSB_W-1:0]   src_lsb;
  logic [AES_LSB_W-1:0]   dst_lsb;
  logic [7:0]             sub_in;
  logic [7:0]             sub_out;

  // Next-state logic; acceptance only in IDLE, where in_ready is high.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt == 4'(AES_NB_BYTES - 1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // cnt = {c, r}: select the source byte and its write-back slot.
  always_comb begin
    src_lsb = byte_lsb(cnt[1:0], cnt[3:2]);
    dst     = SHIFT_ROWS ? shift_dst(cnt[1:0], cnt[3:2]) : cnt;
    dst_lsb = byte_lsb(dst[1:0], dst[3:2]);
    sub_in  = in_reg[src_lsb +: 8];
  end

  sbox u_sbox (
    .a (sub_in),
    .y (sub_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      in_reg    <= '0;
      out_reg   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == ST_IDLE);
      out_valid <= (state_nxt == ST_DONE);
      busy      <= (state_nxt != ST_IDLE);
      if (accept) begin
        in_reg <= state_in;
        cnt    <= '0;
      end
      if (state == ST_RUN) begin
        out_reg[dst_lsb +: 8] <= sub_out;
        cnt                   <= cnt + 4'd1;
      end
    end
  end

  assign state_out = out_reg;

endmodule

// File: doc/aes_sub_shift_serial.md
# aes_sub_shift_serial

Byte-serial SubBytes + ShiftRows stage of the AES round datapath. Accepts a 128-bit state over a valid/ready handshake, pushes its 16 bytes one per cycle through a single `sbox` lookup instance, and writes each substituted byte to its ShiftRows destination. Presents the finished state downstream to MixColumns / AddRoundKey. Trades 16 cycles of latency for one S-box instead of sixteen.

## Interface
Parameters:
- `SHIFT_ROWS`, default 1: 1 = apply ShiftRows on write-back; 0 = SubBytes only, bytes keep their position.

Ports:
- `clk`  input  1  sole clock; all state changes on its rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `in_valid`  input  1  `state_in` holds a state to process.
- `in_ready`  output  1  block can accept a state (high only in IDLE).
- `state_in`  input  128  input state; byte i = `state_in[127-8i -: 8]`, with i = r + 4c (FIPS-197 column-major).
- `out_valid`  output  1  `state_out` holds a finished state (high only in DONE).
- `out_ready`  input  1  downstream accepts `state_out`.
- `state_out`  output  128  result state, same byte ordering as `state_in`.
- `busy`  output  1  high in RUN and DONE.

## Operation
- FSM with three states: IDLE, RUN, DONE.
- IDLE: `in_ready`=1.
  - On `in_valid` && `in_ready`: capture `state_in` into the input register, clear the 4-bit byte counter `cnt`, go to RUN.
  - `in_valid` without acceptance has no effect.
- RUN: each cycle, input byte `cnt` at (r,c) = (`cnt`%4, `cnt`/4) drives the sbox.
  - Result is written to output byte position (r, (c−r) mod 4) when `SHIFT_ROWS`=1, or to position `cnt` when 0.
  - `cnt` increments modulo 16.
  - On the cycle `cnt`=15: write the last byte and go to DONE.
  - `in_valid` is ignored; `in_ready`=0.
- DONE: `out_valid`=1 and `state_out` is stable.
  - On `out_ready`: go to IDLE.
  - Without `out_ready`, hold indefinitely.
- `state_out` is driven directly from the output register.
  - It is only guaranteed meaningful while `out_valid`=1.
  - It keeps the last result after leaving DONE until overwritten in RUN.
- All column arithmetic is 2-bit modulo 4. `cnt` wraps from 15 to 0, with no overflow state.
- Reset, at any time including mid-RUN or DONE:
  - FSM → IDLE; `cnt`=0; input and output registers = 0.
  - Any partially processed state is discarded.
  - Reset has priority over every handshake in the same cycle.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `state_out`=128'h0.
- Accept at edge E0 → RUN for 16 cycles (byte writes at E1..E16) → `out_valid` high after E16.
  - Latency = 16 cycles from accept edge to `out_valid`.
- With `out_ready` held high, the output handshake completes in the first DONE cycle (edge E17). IDLE follows, and the next accept is at E18 at the earliest.
  - Minimum initiation interval is 18 cycles.
- `in_ready` and `out_valid` are never high together.
- The sbox lookup is purely combinational within the RUN cycle; no extra pipeline stage.

## Structure
- Shared package `aes_pkg`:
  - constant `AES_NB_BYTES`=16;
  - state width 128;
  - FSM state encoding (IDLE/RUN/DONE);
  - byte-index helper function mapping (r,c) ↔ bit slice;
  - ShiftRows destination index function.
- One sub-module instance: the existing `sbox`, driven from the `cnt`-selected input byte.
- Everything else (counter, FSM, byte mux/demux) stays in this module.

## Test plan
- Reset then idle: after `rst`, check `in_ready`=1, `out_valid`=0, `busy`=0, `state_out`=0. Hold `in_valid`=0 for 20 cycles → no change.
- FIPS-197 App. B round 1, `SHIFT_ROWS`=1: input `193de3bea0f4e22b9ac68d2ae9f84808` → `d4bf5d30e0b452aeb84111f11e2798e5`. Check `out_valid` rises exactly 16 cycles after the accept edge.
- Same vector with `SHIFT_ROWS`=0 → `d42711aee0bf98f1b8b45de51e415230`. Input `000102030405060708090a0b0c0d0e0f` with `SHIFT_ROWS`=0 → `637c777bf26b6fc53001672bfed7ab76`.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE.
  - `state_out` and `out_valid` stay stable.
  - `in_valid` pulses during RUN and DONE are ignored (`in_ready`=0).
  - Release `out_ready` → IDLE next cycle.
- Reset mid-RUN: assert `rst` at `cnt`=7, then feed all-zero input.
  - Output = all `63` bytes.
  - No byte from the aborted state appears.
- Back-to-back: `in_valid` and `out_ready` held high, three vectors queued → accepts occur every 18 cycles and the three results arrive in order.
